// File: rtl/sync_frame_pkg.sv
// Shared types and constants for the sync-word framed byte extractor.
// Optional checksum state is present only when SYNC_FRAME_EXTRACT_CHECKSUM_EN is defined.
package sync_frame_pkg;

    localparam int LEN_W       = 8;
    localparam int COUNT_W_DEF = 16;
    localparam int MAX_PAYLOAD = 255;

    typedef enum logic [1:0] {
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
        ST_CSUM    = 2'd3,
`endif
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

endpackage

// File: rtl/sync_frame_extract_if.sv
// Upstream byte stream and downstream payload stream of sync_frame_extract.
// master = environment side, slave = extractor side.
interface sync_frame_extract_if;
    import sync_frame_pkg::*;

    logic [LEN_W-1:0] i_m_data;
    logic             i_m_valid;
    logic             o_m_ready;
    logic [LEN_W-1:0] o_s_data;
    logic             o_s_valid;
    logic             o_s_last;
    logic             i_s_ready;

    modport master (
        output i_m_data, i_m_valid, i_s_ready,
        input  o_m_ready, o_s_data, o_s_valid, o_s_last
    );

    modport slave (
        input  i_m_data, i_m_valid, i_s_ready,
        output o_m_ready, o_s_data, o_s_valid, o_s_last
    );

endinterface

// File: rtl/sync_frame_extract_stream_reg_slice.sv
// Single-entry output register (data + last) with valid/ready hold behaviour.
// Accepts a new beat in the same cycle the held beat is taken downstream.
module stream_reg_slice #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    input  logic              i_ready
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              last_q;

    assign o_ready = !valid_q || i_ready;
    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (i_valid && o_ready) begin
            data_q  <= i_data;
            last_q  <= i_last;
            valid_q <= 1'b1;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/sync_frame_extract.sv
// Extracts length-prefixed payloads following a sync indication and counts good frames.
// Define SYNC_FRAME_EXTRACT_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module sync_frame_extract
    import sync_frame_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sync_frame_extract_if.slave bus,
    input  logic               i_detected,
    output logic               o_frame_err,
    output logic [COUNT_W-1:0] o_frame_count
);

    state_e             state_q;
    logic [LEN_W-1:0]   rem_q;
    logic               err_q;
    logic [COUNT_W-1:0] count_q;
    logic               slice_ready;
    logic               accept;
    logic               load;
    logic               m_ready;
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
    logic [LEN_W-1:0]   csum_q;
`endif

    // Back-pressure only matters while payload bytes are flowing into the slice.
    always_comb begin
        m_ready = 1'b1;
        if (!i_rst && state_q == ST_PAYLOAD) begin
            m_ready = slice_ready;
        end
    end

    assign bus.o_m_ready = m_ready;
    assign accept        = bus.i_m_valid && m_ready;
    assign load          = accept && (state_q == ST_PAYLOAD);
    assign o_frame_err   = err_q;
    assign o_frame_count = count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_detected) begin
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        if (bus.i_m_data == '0) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            rem_q   <= bus.i_m_data;
                            state_q <= ST_PAYLOAD;
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
                            csum_q  <= '0;
`endif
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        rem_q  <= rem_q - LEN_W'(1);
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.i_m_data;
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= ST_CSUM;
                        end
`else
                        if (rem_q == LEN_W'(1)) begin
                            count_q <= count_q + COUNT_W'(1);
                            state_q <= ST_IDLE;
                        end
`endif
                    end
                end
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        if (bus.i_m_data == csum_q) begin
                            count_q <= count_q + COUNT_W'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    stream_reg_slice #(
        .DATA_W (LEN_W)
    ) u_out_slice (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (bus.i_m_data),
        .i_last  (rem_q == LEN_W'(1)),
        .i_valid (load),
        .o_ready (slice_ready),
        .o_data  (bus.o_s_data),
        .o_valid (bus.o_s_valid),
        .o_last  (bus.o_s_last),
        .i_ready (bus.i_s_ready)
    );

endmodule

// File: tb/tb_sync_frame_extract.sv
// Self-checking bench for sync_frame_extract: directed frames plus randomized traffic
// against a frame-level reference model with an output scoreboard.
module tb_sync_frame_extract;

    localparam int PH_IDLE = 0;
    localparam int PH_LEN  = 1;
    localparam int PH_PAY  = 2;
    localparam int PH_CSUM = 3;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_detected = 1'b0;
    logic        o_frame_err;
    logic [15:0] o_frame_count;

    sync_frame_extract_if bus ();

    sync_frame_extract #(.COUNT_W(16)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .bus           (bus),
        .i_detected    (i_detected),
        .o_frame_err   (o_frame_err),
        .o_frame_count (o_frame_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: frame phase, bytes still owed, running XOR, pending output beats.
    int          m_phase = PH_IDLE;
    int          m_rem = 0;
    logic [7:0]  m_xor = 8'h00;
    bit          m_err = 1'b0;
    int unsigned m_count = 0;
    bit          m_rst_seen = 1'b1;
    logic [8:0]  sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit mv, input logic [7:0] d, input bit det, input bit sr);
        bit exp_ready;
        bit acc_ok;
        @(negedge clk);
        i_rst = rst;
        bus.i_m_valid = mv;
        bus.i_m_data = d;
        i_detected = det;
        bus.i_s_ready = sr;
        #1;
        check_eq("s_valid", 32'(bus.o_s_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check_eq("s_data", 32'(bus.o_s_data), 32'(sb[0][7:0]));
            check_eq("s_last", 32'(bus.o_s_last), 32'(sb[0][8]));
        end else if (m_rst_seen) begin
            check_eq("rst_data", 32'(bus.o_s_data), 32'd0);
            check_eq("rst_last", 32'(bus.o_s_last), 32'd0);
        end
        exp_ready = rst || !(m_phase == PH_PAY && sb.size() != 0 && !sr);
        check_eq("m_ready", 32'(bus.o_m_ready), 32'(exp_ready));
        check_eq("frame_err", 32'(o_frame_err), 32'(m_err));
        check_eq("frame_count", 32'(o_frame_count), 32'(m_count[15:0]));
        if (rst) begin
            sb.delete();
            m_phase = PH_IDLE;
            m_rem = 0;
            m_err = 1'b0;
            m_count = 0;
            m_rst_seen = 1'b1;
        end else begin
            m_rst_seen = 1'b0;
            m_err = 1'b0;
            acc_ok = mv && exp_ready;
            if (sb.size() != 0 && sr) void'(sb.pop_front());
            case (m_phase)
                PH_IDLE: if (det) m_phase = PH_LEN;
                PH_LEN: if (acc_ok) begin
                    if (d == 8'h00) begin
                        m_err = 1'b1;
                        m_phase = PH_IDLE;
                    end else begin
                        m_rem = int'(d);
                        m_xor = 8'h00;
                        m_phase = PH_PAY;
                    end
                end
                PH_PAY: if (acc_ok) begin
                    sb.push_back({m_rem == 1, d});
                    m_xor = m_xor ^ d;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
                        m_phase = PH_CSUM;
`else
                        m_count = m_count + 1;
                        m_phase = PH_IDLE;
`endif
                    end
                end
                PH_CSUM: if (acc_ok) begin
                    if (d == m_xor) m_count = m_count + 1;
                    else m_err = 1'b1;
                    m_phase = PH_IDLE;
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic reset_dut();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] d;
        bit rst, mv, det, sr;
        bus.i_m_valid = 1'b0;
        bus.i_m_data = 8'h00;
        bus.i_s_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Basic frame 03 11 22 33.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33);
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
        send(8'h00);
`endif
        idle(3);
        check_eq("count_basic", 32'(o_frame_count), 32'd1);

        // Downstream stall while 22 is held.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        send(8'h03); send(8'h11); send(8'h22);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
        check_eq("stall_ready", 32'(bus.o_m_ready), 32'd0);
        send(8'h33);
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
        send(8'h00);
`endif
        idle(3);
        check_eq("count_stall", 32'(o_frame_count), 32'd2);

        // Zero length byte.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        send(8'h00);
        idle(3);
        check_eq("count_zero_len", 32'(o_frame_count), 32'd2);

`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
        // Good and bad checksum.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        send(8'h02); send(8'h01); send(8'h02); send(8'h03);
        idle(2);
        check_eq("count_csum_ok", 32'(o_frame_count), 32'd3);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        send(8'h02); send(8'h01); send(8'h02); send(8'h04);
        idle(2);
        check_eq("count_csum_bad", 32'(o_frame_count), 32'd3);
`endif

        // Reset mid-frame, then a 1-byte frame AA.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        send(8'h05); send(8'h51); send(8'h52);
        reset_dut();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        send(8'h01); send(8'hAA);
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
        send(8'hAA);
`endif
        idle(3);
        check_eq("count_after_rst", 32'(o_frame_count), 32'd1);

        // i_detected held high throughout a length-2 frame and beyond.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h02, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h7E, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
`ifdef SYNC_FRAME_EXTRACT_CHECKSUM_EN
        step(1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
`endif
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        check_eq("det_held_count", 32'(o_frame_count), 32'd2);
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            det = ($urandom_range(0, 5) == 0);
            mv  = ($urandom_range(0, 3) != 0);
            sr  = ($urandom_range(0, 3) != 0);
            d   = 8'($urandom_range(0, 255));
            if (m_phase == PH_LEN)
                d = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 8));
            else if (m_phase == PH_CSUM && $urandom_range(0, 1) == 1)
                d = m_xor;
            step(rst, mv, d, det, sr);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
